vc_pop_arbiter: RTL

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

---
 rtl/vc_pop_arbiter_pkg.sv | 24 ++
 rtl/vc_pop_arbiter_if.sv | 40 ++++
 rtl/vc_pop_arbiter_pop_counter.sv | 17 +
 rtl/vc_pop_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC pop arbiter: state encodings, default
// parameter values, the debug view of the FSM and a saturating helper.
package vc_pop_arbiter_pkg;

  localparam int BW_DEF     = 4;
  localparam int WEIGHT_DEF = 4;
  localparam int CW_DEF     = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SERVE0 = 2'd1;
  localparam logic [1:0] ST_SERVE1 = 2'd2;

  // Internal FSM view exposed on the bus for observation.
  typedef struct packed {
    logic [1:0] state;
    logic [3:0] bcnt;
  } dbg_t;

  // Increment that stops at lim (burst counter never exceeds WEIGHT).
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// Bus between the two VC FIFOs / downstream and the pop arbiter.
//
// Handshake: vcX_rd is a pop strobe driven combinationally; it is only
// asserted while vcX_empty=0 and ds_almost_full=0, and at most one of the
// two is high in a cycle. The FIFO pops on the rising edge where vcX_rd=1,
// and vcX_data must already show the head word during that cycle.
// valid_out=1 marks the cycle after a pop, when data_out/active_vc carry
// the popped word and its source VC.
interface vc_pop_arbiter_if
  import vc_pop_arbiter_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int CW = CW_DEF
);
  logic          vc0_empty;
  logic          vc1_empty;
  logic [BW-1:0] vc0_data;
  logic [BW-1:0] vc1_data;
  logic          ds_almost_full;
  logic          vc0_rd;
  logic          vc1_rd;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          active_vc;
  logic [CW-1:0] pop_cnt0;
  logic [CW-1:0] pop_cnt1;
  dbg_t          dbg;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, ds_almost_full,
    output vc0_rd, vc1_rd, data_out, valid_out, active_vc,
    output pop_cnt0, pop_cnt1, dbg
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, ds_almost_full,
    input  vc0_rd, vc1_rd, data_out, valid_out, active_vc,
    input  pop_cnt0, pop_cnt1, dbg
  );
endinterface

// File: rtl/vc_pop_arbiter_pop_counter.sv
// Free-running per-VC pop counter; wraps silently at 2^CW.
module pop_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          en,
  output logic [CW-1:0] count
);

  // Count one per enabled cycle, modulo 2^CW.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) count <= '0;
    else if (en)  count <= count + CW'(1);
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Two-VC FIFO pop arbiter: VC0 has priority but yields to a waiting VC1
// after WEIGHT consecutive pops; popped words are registered to data_out.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int BW     = BW_DEF,
  parameter int WEIGHT = WEIGHT_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  vc_pop_arbiter_if.master bus
);

  localparam logic [3:0] WLIM = 4'(WEIGHT);

  logic [1:0]    state, state_nx;
  logic [3:0]    bcnt, bcnt_nx;
  logic          pop0, pop1;
  logic [CW-1:0] cnt0, cnt1;
  logic [BW-1:0] data_q;

  // Pop decision and next state; nothing moves under backpressure or reset.
  always_comb begin
    pop0     = 1'b0;
    pop1     = 1'b0;
    state_nx = state;
    bcnt_nx  = bcnt;
    if (reset_L && !bus.ds_almost_full) begin
      case (state)
        ST_IDLE: begin
          if (!bus.vc0_empty) begin
            pop0 = 1'b1; state_nx = ST_SERVE0; bcnt_nx = 4'd1;
          end else if (!bus.vc1_empty) begin
            pop1 = 1'b1; state_nx = ST_SERVE1; bcnt_nx = 4'd0;
          end
        end
        ST_SERVE0: begin
          if (!bus.vc0_empty && ((bcnt < WLIM) || bus.vc1_empty)) begin
            pop0 = 1'b1; bcnt_nx = sat_inc(bcnt, WLIM);
          end else if (!bus.vc1_empty) begin
            pop1 = 1'b1; state_nx = ST_SERVE1; bcnt_nx = 4'd0;
          end else begin
            state_nx = ST_IDLE; bcnt_nx = 4'd0;
          end
        end
        ST_SERVE1: begin
          if (!bus.vc0_empty) begin
            pop0 = 1'b1; state_nx = ST_SERVE0; bcnt_nx = 4'd1;
          end else if (!bus.vc1_empty) begin
            pop1 = 1'b1; bcnt_nx = 4'd0;
          end else begin
            state_nx = ST_IDLE; bcnt_nx = 4'd0;
          end
        end
        default: begin
          state_nx = ST_IDLE; bcnt_nx = 4'd0;
        end
      endcase
    end
  end

  // FSM state and burst counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_IDLE;
      bcnt  <= 4'd0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
    end
  end

  // Capture the popped word; idle cycles drop valid and hold the rest.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q        <= '0;
      bus.valid_out <= 1'b0;
      bus.active_vc <= 1'b0;
    end else if (pop0) begin
      data_q        <= bus.vc0_data;
      bus.valid_out <= 1'b1;
      bus.active_vc <= 1'b0;
    end else if (pop1) begin
      data_q        <= bus.vc1_data;
      bus.valid_out <= 1'b1;
      bus.active_vc <= 1'b1;
    end else begin
      bus.valid_out <= 1'b0;
    end
  end

  pop_counter #(.CW(CW)) u_cnt0 (.clk(clk), .reset_L(reset_L), .en(pop0), .count(cnt0));
  pop_counter #(.CW(CW)) u_cnt1 (.clk(clk), .reset_L(reset_L), .en(pop1), .count(cnt1));

  assign bus.vc0_rd     = pop0;
  assign bus.vc1_rd     = pop1;
  assign bus.data_out   = data_q;
  assign bus.pop_cnt0   = cnt0;
  assign bus.pop_cnt1   = cnt1;
  assign bus.dbg.state  = state;
  assign bus.dbg.bcnt   = bcnt;

endmodule
